// File: rtl/uart_result_packet_serializer.sv
// uart_result_packet_serializer: frames a result word and tag as SOF, TAG, payload MSB-first[, CHK] onto a UART TX byte handshake.
// Optional trailing XOR checksum byte is enabled by defining UART_TX_CHECKSUM_EN.
module uart_result_packet_serializer #(
    parameter int         RESULT_WIDTH = 32,
    parameter logic [7:0] SOF_BYTE     = 8'hA5
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_result_valid,
    input  logic [RESULT_WIDTH-1:0] i_result_data,
    input  logic [7:0]              i_result_tag,
    output logic                    o_result_ready,
    output logic [7:0]              o_tx_uart_data,
    output logic                    o_tx_uart_valid,
    input  logic                    i_tx_uart_ready,
    output logic                    o_busy,
    output logic                    o_frame_done,
    output logic                    o_overrun_error
);
    localparam int NB = RESULT_WIDTH / 8;
    localparam int CW = (NB > 1) ? $clog2(NB) : 1;

    typedef enum logic [2:0] {S_IDLE, S_SOF, S_TAG, S_PAY, S_CHK} state_t;

    state_t                  r_state;
    logic [RESULT_WIDTH-1:0] r_data;
    logic [7:0]              r_tag;
    logic [CW-1:0]           r_cnt;
    logic [CW-1:0]           w_idx;
    logic                    w_accept;
    logic [7:0]              w_cur;
    logic [7:0]              w_next;
`ifdef UART_TX_CHECKSUM_EN
    logic [7:0]              r_chk;
`endif

    assign w_accept = o_tx_uart_valid & i_tx_uart_ready;
    assign w_idx    = r_cnt - CW'(1);
    assign w_cur    = r_data[8*r_cnt +: 8];
    assign w_next   = r_data[8*w_idx +: 8];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state         <= S_IDLE;
            r_data          <= '0;
            r_tag           <= '0;
            r_cnt           <= '0;
            o_result_ready  <= 1'b0;
            o_tx_uart_data  <= '0;
            o_tx_uart_valid <= 1'b0;
            o_busy          <= 1'b0;
            o_frame_done    <= 1'b0;
            o_overrun_error <= 1'b0;
`ifdef UART_TX_CHECKSUM_EN
            r_chk           <= '0;
`endif
        end else begin
            o_frame_done <= 1'b0;
            if (i_result_valid && !o_result_ready)
                o_overrun_error <= 1'b1;
            case (r_state)
                S_IDLE: begin
                    o_result_ready <= 1'b1;
                    if (i_result_valid && o_result_ready) begin
                        r_data          <= i_result_data;
                        r_tag           <= i_result_tag;
                        r_cnt           <= CW'(NB - 1);
                        o_tx_uart_data  <= SOF_BYTE;
                        o_tx_uart_valid <= 1'b1;
                        o_result_ready  <= 1'b0;
                        o_busy          <= 1'b1;
                        r_state         <= S_SOF;
`ifdef UART_TX_CHECKSUM_EN
                        r_chk           <= '0;
`endif
                    end
                end
                S_SOF: if (w_accept) begin
                    o_tx_uart_data <= r_tag;
                    r_state        <= S_TAG;
                end
                S_TAG: if (w_accept) begin
                    o_tx_uart_data <= w_cur;
                    r_state        <= S_PAY;
`ifdef UART_TX_CHECKSUM_EN
                    r_chk          <= r_chk ^ o_tx_uart_data;
`endif
                end
                S_PAY: if (w_accept) begin
`ifdef UART_TX_CHECKSUM_EN
                    r_chk <= r_chk ^ o_tx_uart_data;
`endif
                    if (r_cnt != '0) begin
                        r_cnt          <= w_idx;
                        o_tx_uart_data <= w_next;
                    end else begin
`ifdef UART_TX_CHECKSUM_EN
                        // checksum folds in the payload byte being accepted right now
                        o_tx_uart_data <= r_chk ^ o_tx_uart_data;
                        r_state        <= S_CHK;
`else
                        o_tx_uart_valid <= 1'b0;
                        o_busy          <= 1'b0;
                        o_result_ready  <= 1'b1;
                        o_frame_done    <= 1'b1;
                        r_state         <= S_IDLE;
`endif
                    end
                end
`ifdef UART_TX_CHECKSUM_EN
                S_CHK: if (w_accept) begin
                    o_tx_uart_valid <= 1'b0;
                    o_busy          <= 1'b0;
                    o_result_ready  <= 1'b1;
                    o_frame_done    <= 1'b1;
                    r_state         <= S_IDLE;
                end
`endif
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule
